fft_output_reorder: RTL and testbench

- Sits directly after `fft_top` and consumes its `output_en`/`output_real`/`output_imag` stream.
- That stream arrives in digit-reversed index order; this block re-emits each frame in natural frequency-index order.
- Uses a ping-pong memory of 2×N complex entries, so frames can stream back-to-back with no bubbles at one sample per clock.
- Adds frame markers and an explicit output index for downstream logic and benches.

---
 rtl/fft_output_reorder.sv | 209 ++++++++++++++++++++
 tb/tb_fft_output_reorder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_output_reorder.sv
// fft_output_reorder
// ------------------
// Converts the digit-reversed output stream of the SDF FFT core back into
// natural frequency-index order. A ping-pong memory of 2*N complex entries
// lets one frame be written while the previous one drains, so frames can
// stream back-to-back at one sample per clock with no bubbles.
//
// Parameters:
//   WIDTH  bit width of each real/imag component (two's complement)
//   N      frame length (power of 4 by default, power of 2 with the macro)
//
// Ports:
//   clock         single clock, rising edge
//   reset_n       asynchronous active-low reset
//   input_en      input sample valid (no backpressure)
//   input_real    real part, digit-reversed order
//   input_imag    imaginary part, digit-reversed order
//   output_en     output sample valid
//   output_real   real part, natural order (holds when output_en=0)
//   output_imag   imaginary part, natural order (holds when output_en=0)
//   output_index  natural index of the current output sample
//   output_first  high with output_en on index 0 of each frame
//   busy          partial input frame held, or either bank full
//
// Configuration macro:
//   FFT_REORDER_RADIX2_EN  use plain binary bit reversal (any power-of-2 N)
//                          instead of radix-4 digit reversal.

module fft_output_reorder #(
  parameter int WIDTH = 32,
  parameter int N     = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   input_en,
  input  logic [WIDTH-1:0]       input_real,
  input  logic [WIDTH-1:0]       input_imag,
  output logic                   output_en,
  output logic [WIDTH-1:0]       output_real,
  output logic [WIDTH-1:0]       output_imag,
  output logic [$clog2(N)-1:0]   output_index,
  output logic                   output_first,
  output logic                   busy
);

  localparam int LOG2N = $clog2(N);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  // Write side
  logic [LOG2N-1:0] wcnt_q, wcnt_d;
  logic             wbank_q, wbank_d;
  logic [LOG2N-1:0] wrev;
  logic             wr_wrap;

  // Read side
  logic [LOG2N-1:0] rcnt_q, rcnt_d;
  logic             rbank_q, rbank_d;
  state_t           state_q, state_d;
  logic             rd_en;
  logic             rd_last;

  // One flag per bank: bank holds a complete frame not yet fully read
  logic [1:0]       full_q, full_d;

  // Output register
  logic             out_en_q;
  logic             out_first_q;
  logic [WIDTH-1:0] out_real_q;
  logic [WIDTH-1:0] out_imag_q;
  logic [LOG2N-1:0] out_index_q;
  logic             busy_q;

  // Ping-pong storage; address is {bank, index}
  logic [2*WIDTH-1:0] mem [0:2*N-1];

  // Write address permutation
  genvar gi;
`ifdef FFT_REORDER_RADIX2_EN
  for (gi = 0; gi < LOG2N; gi++) begin : g_rev
    assign wrev[gi] = wcnt_q[LOG2N-1-gi];
  end
`else
  if ((LOG2N % 2) != 0) begin : g_odd_log2n
    $error("fft_output_reorder: radix-4 reversal needs an even log2(N)");
  end
  // Reverse the order of the 2-bit digits
  for (gi = 0; gi < LOG2N / 2; gi++) begin : g_rev
    assign wrev[2*gi+1 -: 2] = wcnt_q[LOG2N-1-2*gi -: 2];
  end
`endif

  // Next-state logic for both sides and the read FSM
  always_comb begin
    wcnt_d  = wcnt_q;
    wbank_d = wbank_q;
    rcnt_d  = rcnt_q;
    rbank_d = rbank_q;
    full_d  = full_q;
    state_d = state_q;
    rd_en   = 1'b0;
    rd_last = 1'b0;
    wr_wrap = input_en && (wcnt_q == LOG2N'(N-1));

    // The first read of a frame happens in the same cycle IDLE sees the
    // full flag, giving one edge of latency from the last write.
    case (state_q)
      IDLE: begin
        if (full_q[rbank_q]) begin
          rd_en   = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        rd_en = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    rd_last = rd_en && (rcnt_q == LOG2N'(N-1));

    if (rd_en) begin
      rcnt_d = rcnt_q + 1'b1;
    end
    if (rd_last) begin
      full_d[rbank_q] = 1'b0;
      rbank_d         = ~rbank_q;
      state_d         = full_q[~rbank_q] ? DRAIN : IDLE;
    end

    // Writer and reader always address different banks when both touch
    // the flags in one cycle, so these updates never collide.
    if (input_en) begin
      wcnt_d = wcnt_q + 1'b1;
      if (wr_wrap) begin
        full_d[wbank_q] = 1'b1;
        wbank_d         = ~wbank_q;
      end
    end
  end

  // Control state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wcnt_q  <= '0;
      wbank_q <= 1'b0;
      rcnt_q  <= '0;
      rbank_q <= 1'b0;
      full_q  <= 2'b00;
      state_q <= IDLE;
      busy_q  <= 1'b0;
    end else begin
      wcnt_q  <= wcnt_d;
      wbank_q <= wbank_d;
      rcnt_q  <= rcnt_d;
      rbank_q <= rbank_d;
      full_q  <= full_d;
      state_q <= state_d;
      busy_q  <= (wcnt_d != '0) || (full_d != 2'b00);
    end
  end

  // Memory write port; contents are deliberately not reset
  always_ff @(posedge clock) begin
    if (input_en) begin
      mem[{wbank_q, wrev}] <= {input_real, input_imag};
    end
  end

  // Registered read port doubling as the output register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_en_q    <= 1'b0;
      out_first_q <= 1'b0;
      out_real_q  <= '0;
      out_imag_q  <= '0;
      out_index_q <= '0;
    end else begin
      out_en_q    <= rd_en;
      out_first_q <= rd_en && (rcnt_q == '0);
      if (rd_en) begin
        {out_real_q, out_imag_q} <= mem[{rbank_q, rcnt_q}];
        out_index_q              <= rcnt_q;
      end
    end
  end

`ifndef SYNTHESIS
  // Writing into a bank still waiting to be drained would corrupt a frame
  always_ff @(posedge clock) begin
    if (reset_n) begin
      assert (!(input_en && full_q[wbank_q]));
    end
  end
`endif

  assign output_en    = out_en_q;
  assign output_first = out_first_q;
  assign output_real  = out_real_q;
  assign output_imag  = out_imag_q;
  assign output_index = out_index_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_fft_output_reorder.sv
module tb_fft_output_reorder;

  localparam int WIDTH = 32;
  localparam int N     = 16;
  localparam int LOG2N = 4;

  logic             clock = 1'b0;
  logic             reset_n;
  logic             input_en;
  logic [WIDTH-1:0] input_real;
  logic [WIDTH-1:0] input_imag;
  logic             output_en;
  logic [WIDTH-1:0] output_real;
  logic [WIDTH-1:0] output_imag;
  logic [LOG2N-1:0] output_index;
  logic             output_first;
  logic             busy;

  fft_output_reorder #(.WIDTH(WIDTH), .N(N)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .input_en     (input_en),
    .input_real   (input_real),
    .input_imag   (input_imag),
    .output_en    (output_en),
    .output_real  (output_real),
    .output_imag  (output_imag),
    .output_index (output_index),
    .output_first (output_first),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Captured outputs: {real, imag, index, first}
  logic [2*WIDTH+LOG2N:0] cap_q[$];
  int                     cap_cyc[$];
  logic [2*WIDTH+LOG2N:0] exp_q[$];

  always @(negedge clock) begin
    if (output_en) begin
      cap_q.push_back({output_real, output_imag, output_index, output_first});
      cap_cyc.push_back(cyc);
    end
  end

  int errors = 0;
  int checks = 0;
  int last_e = 0;
  logic [WIDTH-1:0] fr[N];
  logic [WIDTH-1:0] fi[N];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reversal computed from digits with plain arithmetic
  function automatic int rev_idx(input int k);
    int r = 0;
    int x = k;
`ifdef FFT_REORDER_RADIX2_EN
    for (int d = 0; d < LOG2N; d++) begin
      r = r * 2 + x % 2;
      x = x / 2;
    end
`else
    for (int d = 0; d < LOG2N / 2; d++) begin
      r = r * 4 + x % 4;
      x = x / 4;
    end
`endif
    return r;
  endfunction

  // Natural output n carries the sample that arrived at position rev(n)
  task automatic push_model();
    for (int n = 0; n < N; n++) begin
      exp_q.push_back({fr[rev_idx(n)], fi[rev_idx(n)], LOG2N'(n), (n == 0)});
    end
  endtask

  task automatic drive_frame(input int gap_mode, input int nsamp, input bit chk_busy);
    for (int k = 0; k < nsamp; k++) begin
      int g;
      g = 0;
      if (gap_mode == 1 && k > 0) g = 1;
      else if (gap_mode == 2) g = $urandom_range(0, 2);
      input_en = 1'b0;
      repeat (g) begin
        @(negedge clock);
        if (chk_busy && k > 0) check("busy_gap", busy, 1);
      end
      input_en   = 1'b1;
      input_real = fr[k];
      input_imag = fi[k];
      @(negedge clock);
      if (chk_busy) check("busy_in", busy, 1);
    end
    input_en = 1'b0;
    last_e   = cyc;
    if (nsamp == N) push_model();
  endtask

  task automatic wait_outputs(input int m, input int budget);
    int t = 0;
    while (cap_q.size() < m && t < budget) begin
      @(negedge clock);
      #1;
      t++;
    end
  endtask

  task automatic compare_all(input string tag);
    int sz;
    check({tag, "_count"}, cap_q.size(), exp_q.size());
    sz = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int i = 0; i < sz; i++) begin
      check($sformatf("%s_out%0d", tag, i), cap_q[i], exp_q[i]);
    end
    $display("%s: %0d outputs compared", tag, sz);
    cap_q.delete();
    cap_cyc.delete();
    exp_q.delete();
  endtask

  initial begin
    int found;
    reset_n    = 1'b0;
    input_en   = 1'b0;
    input_real = '0;
    input_imag = '0;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_en", output_en, 0);
    check("rst_real", output_real, 0);
    check("rst_imag", output_imag, 0);
    check("rst_index", output_index, 0);
    check("rst_first", output_first, 0);
    check("rst_busy", busy, 0);
    reset_n = 1'b1;
    @(negedge clock);

    // Ramp frame, gapless
    for (int k = 0; k < N; k++) begin
      fr[k] = k;
      fi[k] = -k;
    end
    drive_frame(0, N, 1'b0);
    wait_outputs(N, 40);
    if (cap_q.size() == N) begin
      check("latency", cap_cyc[0], last_e + 1);
`ifdef FFT_REORDER_RADIX2_EN
      check("ramp_idx1", cap_q[1][2*WIDTH+LOG2N -: WIDTH], 8);
      check("ramp_idx3", cap_q[3][2*WIDTH+LOG2N -: WIDTH], 12);
      check("ramp_idx6", cap_q[6][2*WIDTH+LOG2N -: WIDTH], 6);
      check("ramp_idx6_im", cap_q[6][WIDTH+LOG2N -: WIDTH], 32'hFFFF_FFFA);
`else
      check("ramp_idx1", cap_q[1][2*WIDTH+LOG2N -: WIDTH], 4);
      check("ramp_idx4", cap_q[4][2*WIDTH+LOG2N -: WIDTH], 1);
      check("ramp_idx6", cap_q[6][2*WIDTH+LOG2N -: WIDTH], 9);
      check("ramp_idx6_im", cap_q[6][WIDTH+LOG2N -: WIDTH], 32'hFFFF_FFF7);
`endif
    end
    compare_all("ramp");

    // Three frames back-to-back
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < N; k++) begin
        fr[k] = 16 * f + k;
        fi[k] = $urandom;
      end
      drive_frame(0, N, 1'b0);
    end
    wait_outputs(3 * N, 80);
    if (cap_q.size() == 3 * N) begin
      for (int j = 1; j < 3 * N; j++) begin
        check($sformatf("b2b_cycle%0d", j), cap_cyc[j], cap_cyc[0] + j);
      end
`ifdef FFT_REORDER_RADIX2_EN
      check("b2b_f2_idx4", cap_q[36][2*WIDTH+LOG2N -: WIDTH], 34);
`else
      check("b2b_f2_idx4", cap_q[36][2*WIDTH+LOG2N -: WIDTH], 33);
`endif
    end
    compare_all("b2b");

    // Input toggled every cycle; busy tracked through the drain
    for (int k = 0; k < N; k++) begin
      fr[k] = k;
      fi[k] = -k;
    end
    repeat (3) @(negedge clock);
    check("busy_idle", busy, 0);
    drive_frame(1, N, 1'b1);
    found = 0;
    for (int t = 0; t < 40 && found == 0; t++) begin
      @(negedge clock);
      #1;
      if (output_en && output_index == 4'd15) found = 1;
      else check("busy_drain", busy, 1);
    end
    check("gap_drain_end", found, 1);
    @(negedge clock);
    #1;
    check("busy_after", busy, 0);
    check("en_after", output_en, 0);
    compare_all("gaps");

    // Reset in the middle of an input frame
    for (int k = 0; k < N; k++) begin
      fr[k] = $urandom;
      fi[k] = $urandom;
    end
    drive_frame(2, 7, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("midframe_busy", busy, 0);
    check("midframe_en", output_en, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < N; k++) begin
      fr[k] = $urandom;
      fi[k] = $urandom;
    end
    drive_frame(2, N, 1'b0);
    wait_outputs(N, 100);
    repeat (5) @(negedge clock);
    compare_all("midframe");

    // Reset during the drain
    for (int k = 0; k < N; k++) begin
      fr[k] = $urandom;
      fi[k] = $urandom;
    end
    drive_frame(0, N, 1'b0);
    found = 0;
    for (int t = 0; t < 40 && found == 0; t++) begin
      @(negedge clock);
      #1;
      if (output_en && output_index == 4'd5) found = 1;
    end
    check("middrain_found", found, 1);
    #2 reset_n = 1'b0;
    #1;
    check("middrain_en", output_en, 0);
    check("middrain_index", output_index, 0);
    check("middrain_real", output_real, 0);
    check("middrain_count", cap_q.size(), 6);
    cap_q.delete();
    cap_cyc.delete();
    exp_q.delete();
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (30) @(negedge clock);
    check("middrain_silent", cap_q.size(), 0);

    // Random frames with random gaps
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < N; k++) begin
        fr[k] = $urandom;
        fi[k] = $urandom;
      end
      drive_frame((f == 1) ? 0 : 2, N, 1'b0);
    end
    wait_outputs(4 * N, 400);
    repeat (5) @(negedge clock);
    compare_all("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
